// File: rtl/mem_ctrl_collector_if.sv
// mem_ctrl_collector_if: packet types and the bundled port interface of the
// memory-pipe completion collector.
//   slave  modport : collector side (inputs *_i, outputs *_o)
//   master modport : writeback / active-list / retire side
// Signals:
//   recoverFlag_i  pipeline recovery (synchronous flush)
//   ctrlPacket_i   completion packet from memory writeback (.valid qualified)
//   ldVioPacket_i  load-violation packet from memory writeback
//   alCtrlPacket_o / alCtrlValid_o / alCtrlReady_i  FIFO head handshake
//   ldVioPacket_o / ldVioValid_o / ldVioAck_i       held violation handshake
//   stall_o        upstream backpressure
//   overflow_o     sticky dropped-packet flag
package mem_col_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] seqNo;
        logic [5:0]  alId;
        logic        exception;
    } ctrlPkt;

    typedef struct packed {
        logic        valid;
        logic [31:0] seqNo;
        logic [5:0]  alId;
    } ldVioPkt;
endpackage

interface mem_ctrl_collector_if;
    import mem_col_pkg::*;

    logic    recoverFlag_i;
    ctrlPkt  ctrlPacket_i;
    ldVioPkt ldVioPacket_i;
    ctrlPkt  alCtrlPacket_o;
    logic    alCtrlValid_o;
    logic    alCtrlReady_i;
    ldVioPkt ldVioPacket_o;
    logic    ldVioValid_o;
    logic    ldVioAck_i;
    logic    stall_o;
    logic    overflow_o;

    modport slave (
        input  recoverFlag_i, ctrlPacket_i, ldVioPacket_i, alCtrlReady_i, ldVioAck_i,
        output alCtrlPacket_o, alCtrlValid_o, ldVioPacket_o, ldVioValid_o, stall_o, overflow_o
    );

    modport master (
        output recoverFlag_i, ctrlPacket_i, ldVioPacket_i, alCtrlReady_i, ldVioAck_i,
        input  alCtrlPacket_o, alCtrlValid_o, ldVioPacket_o, ldVioValid_o, stall_o, overflow_o
    );
endinterface

// File: rtl/mem_ctrl_collector.sv
// mem_ctrl_collector: completion collector for the load/store pipe.
// Buffers writeback control packets in a DEPTH-entry FIFO drained to the
// active list under valid/ready, and holds the oldest outstanding load
// violation until retire acknowledges it.
// Ports:
//   clk    clock, rising edge
//   reset  asynchronous active-low reset
//   bus    mem_ctrl_collector_if.slave (see interface file for signals)
// Parameter: DEPTH FIFO entries (power of two, >= 2).
// Optional feature macro: MEMCOL_OVERFLOW_CHECK_EN -- when defined, a dropped
// enqueue sets a sticky overflow_o (cleared only by reset); otherwise
// overflow_o is tied low and no flag register exists.
module mem_ctrl_collector
    import mem_col_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_ctrl_collector_if.slave   bus
);
    localparam int             PW      = $clog2(DEPTH);
    localparam logic [PW:0]    DEPTH_C = (PW+1)'(DEPTH);

    ctrlPkt          entry_q [DEPTH];
    logic [PW-1:0]   head_q, tail_q;
    logic [PW:0]     count_q;
    ldVioPkt         vio_q, vio_d;
    logic            vio_v_q, vio_v_d;

    logic            deq, enq, full;
    logic [31:0]     seq_diff;

    // Dequeue is only meaningful with something queued; a full FIFO still
    // accepts when the head leaves in the same cycle.
    assign deq  = (count_q != '0) && bus.alCtrlReady_i;
    assign full = (count_q == DEPTH_C);
    assign enq  = bus.ctrlPacket_i.valid && (!full || deq);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (bus.recoverFlag_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq) begin
                entry_q[tail_q] <= bus.ctrlPacket_i;
                tail_q          <= tail_q + 1'b1;
            end
            if (deq) head_q <= head_q + 1'b1;
            case ({enq, deq})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Wrap-aware age: incoming is older when (in - held) is negative.
    assign seq_diff = bus.ldVioPacket_i.seqNo - vio_q.seqNo;

    always_comb begin
        vio_d   = vio_q;
        vio_v_d = vio_v_q;
        if (bus.recoverFlag_i) begin
            vio_d   = '0;
            vio_v_d = 1'b0;
        end else if (bus.ldVioPacket_i.valid) begin
            if (!vio_v_q || bus.ldVioAck_i || seq_diff[31]) begin
                vio_d   = bus.ldVioPacket_i;
                vio_v_d = 1'b1;
            end
        end else if (bus.ldVioAck_i) begin
            vio_d   = '0;
            vio_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vio_q   <= '0;
            vio_v_q <= 1'b0;
        end else begin
            vio_q   <= vio_d;
            vio_v_q <= vio_v_d;
        end
    end

    assign bus.alCtrlValid_o  = (count_q != '0);
    assign bus.alCtrlPacket_o = bus.alCtrlValid_o ? entry_q[head_q] : '0;
    assign bus.ldVioValid_o   = vio_v_q;
    assign bus.ldVioPacket_o  = vio_v_q ? vio_q : '0;
    // One slot of headroom for the packet already in the upstream register.
    assign bus.stall_o        = (count_q >= DEPTH_C - 1'b1);

`ifdef MEMCOL_OVERFLOW_CHECK_EN
    logic overflow_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
        end else if (!bus.recoverFlag_i && bus.ctrlPacket_i.valid && !enq) begin
            overflow_q <= 1'b1;
`ifndef SYNTHESIS
            $error("mem_ctrl_collector: dropped ctrl packet seqNo %0h", bus.ctrlPacket_i.seqNo);
`endif
        end
    end
    assign bus.overflow_o = overflow_q;
`else
    assign bus.overflow_o = 1'b0;
`endif
endmodule

// File: tb/tb_mem_ctrl_collector.sv
module tb_mem_ctrl_collector;
    import mem_col_pkg::*;

    localparam int DEPTH = 4;
`ifdef MEMCOL_OVERFLOW_CHECK_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk, reset;
    mem_ctrl_collector_if bus();

    mem_ctrl_collector #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: an ordered queue of accepted packets plus the held violation.
    ctrlPkt  mq[$];
    bit      vh;
    ldVioPkt vq;
    bit      ovf;

    function automatic void model_reset(bit clr_ovf);
        mq.delete();
        vh = 1'b0;
        vq = '0;
        if (clr_ovf) ovf = 1'b0;
    endfunction

    function automatic void model_step();
        ctrlPkt  c = bus.ctrlPacket_i;
        ldVioPkt v = bus.ldVioPacket_i;
        if (bus.recoverFlag_i) begin
            model_reset(1'b0);
            return;
        end
        if (mq.size() > 0 && bus.alCtrlReady_i) void'(mq.pop_front());
        if (c.valid) begin
            if (mq.size() < DEPTH) mq.push_back(c);
            else if (OVF_EN) ovf = 1'b1;
        end
        if (v.valid) begin
            if (!vh || bus.ldVioAck_i || ($signed(v.seqNo - vq.seqNo) < 0)) begin
                vh = 1'b1;
                vq = v;
            end
        end else if (bus.ldVioAck_i) begin
            vh = 1'b0;
            vq = '0;
        end
    endfunction

    task automatic drive(bit cv, logic [31:0] cs, bit rdy, bit vv, logic [31:0] vs, bit ack, bit rec);
        bus.ctrlPacket_i  = '{valid: cv, seqNo: cs, alId: 6'($urandom), exception: 1'($urandom)};
        bus.ldVioPacket_i = '{valid: vv, seqNo: vs, alId: 6'($urandom)};
        bus.alCtrlReady_i = rdy;
        bus.ldVioAck_i    = ack;
        bus.recoverFlag_i = rec;
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #12;
        n_chk++; if (bus.alCtrlValid_o !== 1'b0) $display("FAIL reset_alvalid: got %0b exp 0", bus.alCtrlValid_o); else n_pass++;
        n_chk++; if (bus.alCtrlPacket_o !== '0) $display("FAIL reset_alpkt: got %0h exp 0", bus.alCtrlPacket_o); else n_pass++;
        n_chk++; if (bus.ldVioValid_o !== 1'b0) $display("FAIL reset_viovalid: got %0b exp 0", bus.ldVioValid_o); else n_pass++;
        n_chk++; if (bus.stall_o !== 1'b0) $display("FAIL reset_stall: got %0b exp 0", bus.stall_o); else n_pass++;
        n_chk++; if (bus.overflow_o !== 1'b0) $display("FAIL reset_ovf: got %0b exp 0", bus.overflow_o); else n_pass++;
        model_reset(1'b1);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] exp_seq[3] = '{32'd10, 32'd11, 32'd12};
        for (int i = 0; i < 3; i++) begin
            drive(1, exp_seq[i], 0, 0, 0, 0, 0);
            step();
            n_chk++; if (bus.stall_o !== (i == 2)) $display("FAIL basic_stall%0d: got %0b exp %0b", i, bus.stall_o, i == 2); else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (bus.alCtrlValid_o !== 1'b1 || bus.alCtrlPacket_o.seqNo !== exp_seq[i])
                $display("FAIL basic_drain%0d: got v=%0b seq=%0d exp v=1 seq=%0d", i, bus.alCtrlValid_o, bus.alCtrlPacket_o.seqNo, exp_seq[i]);
            else n_pass++;
            drive(0, 0, 1, 0, 0, 0, 0);
            step();
        end
        n_chk++; if (bus.alCtrlValid_o !== 1'b0) $display("FAIL basic_empty: got %0b exp 0", bus.alCtrlValid_o); else n_pass++;
    endtask

    task automatic test_full_drop();
        logic [31:0] exp_seq[4] = '{32'd2, 32'd3, 32'd4, 32'd21};
        for (int i = 1; i <= 4; i++) begin
            drive(1, 32'(i), 0, 0, 0, 0, 0);
            step();
        end
        drive(1, 32'd20, 0, 0, 0, 0, 0);
        step();
        n_chk++; if (bus.alCtrlPacket_o.seqNo !== 32'd1) $display("FAIL full_head: got %0d exp 1", bus.alCtrlPacket_o.seqNo); else n_pass++;
        n_chk++; if (bus.overflow_o !== OVF_EN) $display("FAIL full_ovf: got %0b exp %0b", bus.overflow_o, OVF_EN); else n_pass++;
        drive(1, 32'd21, 1, 0, 0, 0, 0);
        step();
        n_chk++; if (bus.stall_o !== 1'b1) $display("FAIL full_stall: got %0b exp 1", bus.stall_o); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (bus.alCtrlValid_o !== 1'b1 || bus.alCtrlPacket_o.seqNo !== exp_seq[i])
                $display("FAIL full_drain%0d: got v=%0b seq=%0d exp v=1 seq=%0d", i, bus.alCtrlValid_o, bus.alCtrlPacket_o.seqNo, exp_seq[i]);
            else n_pass++;
            drive(0, 0, 1, 0, 0, 0, 0);
            step();
        end
        n_chk++; if (bus.alCtrlValid_o !== 1'b0) $display("FAIL full_empty: got %0b exp 0", bus.alCtrlValid_o); else n_pass++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 9; i++) begin
            drive(1, 32'(30 + i), 1, 0, 0, 0, 0);
            step();
            n_chk++; if (bus.alCtrlPacket_o.seqNo !== 32'(30 + i) || bus.stall_o !== 1'b0)
                $display("FAIL wrap%0d: got seq=%0d stall=%0b exp seq=%0d stall=0", i, bus.alCtrlPacket_o.seqNo, bus.stall_o, 30 + i);
            else n_pass++;
        end
        drive(0, 0, 1, 0, 0, 0, 0);
        step();
        n_chk++; if (bus.alCtrlValid_o !== 1'b0) $display("FAIL wrap_empty: got %0b exp 0", bus.alCtrlValid_o); else n_pass++;
    endtask

    task automatic test_vio();
        logic [31:0] in_seq[3]  = '{32'hFFFF_FFF0, 32'h0000_0005, 32'hFFFF_FFE0};
        logic [31:0] exp_seq[3] = '{32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFE0};
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, in_seq[i], 0, 0);
            step();
            n_chk++; if (bus.ldVioValid_o !== 1'b1 || bus.ldVioPacket_o.seqNo !== exp_seq[i])
                $display("FAIL vio_hold%0d: got v=%0b seq=%0h exp v=1 seq=%0h", i, bus.ldVioValid_o, bus.ldVioPacket_o.seqNo, exp_seq[i]);
            else n_pass++;
        end
        drive(0, 0, 0, 1, 32'd7, 1, 0);
        step();
        n_chk++; if (bus.ldVioValid_o !== 1'b1 || bus.ldVioPacket_o.seqNo !== 32'd7)
            $display("FAIL vio_ackcap: got v=%0b seq=%0h exp v=1 seq=7", bus.ldVioValid_o, bus.ldVioPacket_o.seqNo);
        else n_pass++;
        drive(0, 0, 0, 0, 0, 1, 0);
        step();
        n_chk++; if (bus.ldVioValid_o !== 1'b0 || bus.ldVioPacket_o !== '0)
            $display("FAIL vio_ackclr: got v=%0b pkt=%0h exp v=0 pkt=0", bus.ldVioValid_o, bus.ldVioPacket_o);
        else n_pass++;
    endtask

    task automatic test_recover();
        drive(1, 32'd40, 0, 1, 32'd100, 0, 0);
        step();
        drive(1, 32'd41, 0, 0, 0, 0, 0);
        step();
        drive(1, 32'd42, 1, 1, 32'd50, 1, 1);
        step();
        n_chk++; if (bus.alCtrlValid_o !== 1'b0) $display("FAIL rec_alvalid: got %0b exp 0", bus.alCtrlValid_o); else n_pass++;
        n_chk++; if (bus.ldVioValid_o !== 1'b0) $display("FAIL rec_viovalid: got %0b exp 0", bus.ldVioValid_o); else n_pass++;
        n_chk++; if (bus.stall_o !== 1'b0) $display("FAIL rec_stall: got %0b exp 0", bus.stall_o); else n_pass++;
        n_chk++; if (bus.overflow_o !== ovf) $display("FAIL rec_ovf: got %0b exp %0b", bus.overflow_o, ovf); else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'(60 + i), 0, 1, 32'(60 + i), 0, 0);
            step();
        end
        #2 reset = 1'b0;
        #1;
        model_reset(1'b1);
        n_chk++; if (bus.alCtrlValid_o !== 1'b0 || bus.alCtrlPacket_o !== '0 || bus.stall_o !== 1'b0)
            $display("FAIL rstmid_fifo: got v=%0b pkt=%0h stall=%0b exp all 0", bus.alCtrlValid_o, bus.alCtrlPacket_o, bus.stall_o);
        else n_pass++;
        n_chk++; if (bus.ldVioValid_o !== 1'b0 || bus.ldVioPacket_o !== '0 || bus.overflow_o !== 1'b0)
            $display("FAIL rstmid_vio: got v=%0b pkt=%0h ovf=%0b exp all 0", bus.ldVioValid_o, bus.ldVioPacket_o, bus.overflow_o);
        else n_pass++;
        #1 reset = 1'b1;
        drive(1, 32'd77, 0, 0, 0, 0, 0);
        step();
        n_chk++; if (bus.alCtrlValid_o !== 1'b1 || bus.alCtrlPacket_o.seqNo !== 32'd77 || bus.stall_o !== 1'b0)
            $display("FAIL rstmid_enq: got v=%0b seq=%0d stall=%0b exp v=1 seq=77 stall=0", bus.alCtrlValid_o, bus.alCtrlPacket_o.seqNo, bus.stall_o);
        else n_pass++;
    endtask

    task automatic test_random();
        ctrlPkt  exp_c;
        ldVioPkt exp_v;
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 99) < 60), $urandom, 1'($urandom_range(0, 99) < 45),
                  1'($urandom_range(0, 99) < 30), $urandom_range(0, 63) - 32, 1'($urandom_range(0, 99) < 20),
                  1'($urandom_range(0, 99) < 3));
            step();
            exp_c = (mq.size() > 0) ? mq[0] : '0;
            exp_v = vh ? vq : '0;
            n_chk++; if (bus.alCtrlValid_o !== (mq.size() > 0) || bus.alCtrlPacket_o !== exp_c)
                $display("FAIL rnd_ctrl@%0d: got v=%0b pkt=%0h exp v=%0b pkt=%0h", i, bus.alCtrlValid_o, bus.alCtrlPacket_o, mq.size() > 0, exp_c);
            else n_pass++;
            n_chk++; if (bus.ldVioValid_o !== vh || bus.ldVioPacket_o !== exp_v)
                $display("FAIL rnd_vio@%0d: got v=%0b pkt=%0h exp v=%0b pkt=%0h", i, bus.ldVioValid_o, bus.ldVioPacket_o, vh, exp_v);
            else n_pass++;
            n_chk++; if (bus.stall_o !== (mq.size() >= DEPTH - 1) || bus.overflow_o !== ovf)
                $display("FAIL rnd_flags@%0d: got stall=%0b ovf=%0b exp stall=%0b ovf=%0b", i, bus.stall_o, bus.overflow_o, mq.size() >= DEPTH - 1, ovf);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_drop();
        test_wrap();
        test_vio();
        test_recover();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_ctrl_collector.md
# mem_ctrl_collector

Completion collector for the memory (load/store) pipe. It receives the per-cycle control packets and load-violation packets from the memory writeback stage. Control packets are buffered in a small FIFO and drained to the active-list completion port under a valid/ready handshake. The oldest outstanding load violation is held until the retire logic acknowledges it.

## Interface
- DEPTH, 4: control-packet FIFO entries; power of two, ≥ 2
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- recoverFlag_i  in  1  pipeline recovery; synchronous flush
- ctrlPacket_i  in  ctrlPkt  completion packet from memory writeback; qualified by .valid
- ldVioPacket_i  in  ldVioPkt  load-violation packet from memory writeback; qualified by .valid
- alCtrlPacket_o  out  ctrlPkt  FIFO head toward active list
- alCtrlValid_o  out  1  FIFO non-empty
- alCtrlReady_i  in  1  active list accepts head this cycle
- ldVioPacket_o  out  ldVioPkt  held oldest violation
- ldVioValid_o  out  1  violation held
- ldVioAck_i  in  1  retire logic consumed held violation
- stall_o  out  1  upstream backpressure
- overflow_o  out  1  sticky overflow flag (see Configuration)

## Operation
- State:
  - DEPTH-entry ctrlPkt array
  - head/tail pointers, log2(DEPTH) bits each, wrapping modulo DEPTH
  - count, log2(DEPTH)+1 bits
  - one violation register plus its valid bit
  - overflow flag
- Enqueue request: ctrlPacket_i.valid.
  - Accepted when count < DEPTH, or when count == DEPTH and a dequeue occurs the same cycle.
  - Accepted packet is written at tail; tail increments.
- Dequeue: alCtrlValid_o & alCtrlReady_i. Head increments.
- Count update: +1 on accepted enqueue only, −1 on dequeue only, unchanged when both occur.
- alCtrlValid_o = (count != 0). alCtrlPacket_o = entry[head] when valid, all-zero otherwise.
- alCtrlReady_i is ignored when the FIFO is empty.
- stall_o = (count ≥ DEPTH−1), decoded from registered count. This covers the one-cycle writeback register upstream.
- Rejected enqueue (full, no dequeue): the packet is dropped.
- Violation capture on ldVioPacket_i.valid:
  - No violation held, or ldVioAck_i asserted this cycle: capture the incoming packet.
  - Violation held and not acked: keep whichever is older. Older means the wrap-aware comparison (signed(in.seqNo − held.seqNo) < 0) selects the incoming one.
  - ldVioAck_i with no new violation clears ldVioValid_o.
  - ldVioPacket_o is all-zero when ldVioValid_o = 0.
- recoverFlag_i flushes, with priority over same-cycle enqueue, dequeue, capture and ack:
  - clears pointers, count and the violation register
  - input packets in that cycle are discarded
  - overflow_o is not cleared
- Reset (reset = 0, asynchronous): all state and all outputs go to 0, including overflow_o.

## Timing
- Enqueue-to-output latency: 1 cycle. A packet accepted at edge N is visible at alCtrlPacket_o after edge N. There is no same-cycle bypass.
- Full-FIFO throughput with alCtrlReady_i held high: 1 packet per cycle.
- Violation latency: 1 cycle from ldVioPacket_i.valid to ldVioValid_o.
- The ack takes effect at the same edge it is sampled.
- stall_o changes one cycle after the count change that causes it.
- Reset asserted mid-operation: outputs go to 0 immediately, without waiting for a clock edge. First enqueue is accepted on the first edge after deassertion.

## Configuration
- MEMCOL_OVERFLOW_CHECK_EN
  - Defined: a rejected enqueue sets overflow_o, which stays set until reset. Simulation also issues $error with the packet's seqNo.
  - Undefined: overflow_o is tied 0, the flag register is not built, and dropped packets are silent.
  - FIFO behaviour is identical either way.

## Test plan
- Reset release, then 3 valid packets seqNo 10, 11, 12 with alCtrlReady_i = 0 → count 3, stall_o = 1 after the third enqueue, head shows seqNo 10. Raise ready → 10, 11, 12 emerge on consecutive cycles, then alCtrlValid_o = 0.
- Fill to 4 entries and keep ready = 0. Present seqNo 20 → dropped; with the macro, overflow_o = 1. Next cycle present seqNo 21 with ready = 1 → accepted (simultaneous deq/enq at full), count stays 4.
- Tail wrap: 9 enqueue/dequeue pairs with ready = 1 → strict seqNo order preserved across pointer wrap, count never exceeds 1.
- Violations seqNo 0xFFFFFFF0, then 0x00000005, then 0xFFFFFFE0 without ack → held value is 0xFFFFFFF0 (unchanged), then 0xFFFFFFE0. Ack together with a new violation 7 → held becomes 7.
- 2 entries queued and a violation held. Assert recoverFlag_i together with a valid ctrlPacket_i and ldVioPacket_i → next cycle alCtrlValid_o = 0, ldVioValid_o = 0, stall_o = 0, overflow_o unchanged.
- Assert reset mid-stream with 3 entries queued → all outputs 0 before the next edge. After release, a single enqueue appears one cycle later.
